// File: rtl/fmc_bus_arbiter.sv
`default_nettype none
// ============================================================================
// fmc_bus_arbiter : shares the sys_clk core bus between the FMC strobe master
//                   (m0, priority) and an internal req/ack master (m1).
// Revision 1.0
// ============================================================================
module fmc_bus_arbiter #(
    parameter int ADDR_BITS  = 24,
    parameter int DATA_BITS  = 32,
    parameter int RD_LATENCY = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [ADDR_BITS-1:0] m0_addr,
    input  logic                 m0_wr_en,
    input  logic                 m0_rd_en,
    input  logic [DATA_BITS-1:0] m0_data_out,
    output logic [DATA_BITS-1:0] m0_data_in,
    output logic                 m0_rd_valid,
    input  logic                 m1_req,
    input  logic                 m1_we,
    input  logic [ADDR_BITS-1:0] m1_addr,
    input  logic [DATA_BITS-1:0] m1_wdata,
    output logic [DATA_BITS-1:0] m1_rdata,
    output logic                 m1_ack,
    output logic [ADDR_BITS-1:0] s_addr,
    output logic                 s_wr_en,
    output logic                 s_rd_en,
    output logic [DATA_BITS-1:0] s_data_out,
    input  logic [DATA_BITS-1:0] s_data_in,
    output logic                 busy,
    output logic                 err_overflow
);
    localparam logic [3:0] c_rd_latency = 4'(RD_LATENCY);
    localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t               state;
    logic                 pend_valid;
    logic                 pend_we;
    logic [ADDR_BITS-1:0] pend_addr;
    logic [DATA_BITS-1:0] pend_data;
    logic [3:0]           starve_cnt;
    logic [3:0]           lat_cnt;
    logic                 owner_m1;

    logic                 strobe;
    logic                 m0_cand;
    logic                 grant_m0;
    logic                 grant_m1;
    logic                 drained;
    logic                 take_live;
    logic                 grant_we;
    logic [ADDR_BITS-1:0] grant_addr;
    logic [DATA_BITS-1:0] grant_data;

    // Arbitration: the pending buffer outranks a live strobe for the m0 slot.
    always_comb begin
        strobe    = m0_wr_en | m0_rd_en;
        m0_cand   = pend_valid | strobe;
        grant_m1  = 1'b0;
        grant_m0  = 1'b0;
        if (state == IDLE) begin
            grant_m1 = m1_req & (~m0_cand | (starve_cnt == c_starve_max));
            grant_m0 = m0_cand & ~grant_m1;
        end
        drained   = grant_m0 & pend_valid;
        take_live = grant_m0 & ~pend_valid;
        if (grant_m1) begin
            grant_we   = m1_we;
            grant_addr = m1_addr;
            grant_data = m1_wdata;
        end else if (pend_valid) begin
            grant_we   = pend_we;
            grant_addr = pend_addr;
            grant_data = pend_data;
        end else begin
            grant_we   = m0_wr_en;
            grant_addr = m0_addr;
            grant_data = m0_data_out;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state        <= IDLE;
            pend_valid   <= 1'b0;
            pend_we      <= 1'b0;
            pend_addr    <= '0;
            pend_data    <= '0;
            starve_cnt   <= 4'd0;
            lat_cnt      <= 4'd0;
            owner_m1     <= 1'b0;
            m0_data_in   <= '0;
            m0_rd_valid  <= 1'b0;
            m1_rdata     <= '0;
            m1_ack       <= 1'b0;
            s_addr       <= '0;
            s_wr_en      <= 1'b0;
            s_rd_en      <= 1'b0;
            s_data_out   <= '0;
            busy         <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            s_wr_en     <= 1'b0;
            s_rd_en     <= 1'b0;
            m0_rd_valid <= 1'b0;
            m1_ack      <= 1'b0;

            // A live strobe issued straight from IDLE never touches the buffer.
            if (strobe && !take_live) begin
                if (!pend_valid || drained) begin
                    pend_valid <= 1'b1;
                    pend_we    <= m0_wr_en;
                    pend_addr  <= m0_addr;
                    pend_data  <= m0_data_out;
                end else begin
                    err_overflow <= 1'b1;
                end
            end else if (drained) begin
                pend_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (grant_m0 || grant_m1) begin
                        owner_m1   <= grant_m1;
                        s_addr     <= grant_addr;
                        s_data_out <= grant_data;
                        busy       <= 1'b1;
                        if (grant_we) begin
                            state   <= WRITE;
                            s_wr_en <= 1'b1;
                        end else begin
                            state   <= READ;
                            s_rd_en <= 1'b1;
                        end
                        if (grant_m1) begin
                            starve_cnt <= 4'd0;
                        end else if (m1_req && starve_cnt != c_starve_max) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                    end
                end
                WRITE: begin
                    state  <= DONE;
                    m1_ack <= owner_m1;
                end
                READ: begin
                    state   <= WAIT;
                    lat_cnt <= c_rd_latency;
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - 4'd1;
                    if (lat_cnt == 4'd1) begin
                        state <= DONE;
                        if (owner_m1) begin
                            m1_ack   <= 1'b1;
                            m1_rdata <= s_data_in;
                        end else begin
                            m0_rd_valid <= 1'b1;
                            m0_data_in  <= s_data_in;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fmc_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_fmc_bus_arbiter : scoreboard bench with a transaction-level timing model.
// Revision 1.0
// ============================================================================
module tb_fmc_bus_arbiter;
    localparam int AB   = 24;
    localparam int DB   = 32;
    localparam int LAT  = 2;
    localparam int SMAX = 4;

    logic          sys_clk;
    logic          sys_rst;
    logic [AB-1:0] m0_addr;
    logic          m0_wr_en;
    logic          m0_rd_en;
    logic [DB-1:0] m0_data_out;
    logic [DB-1:0] m0_data_in;
    logic          m0_rd_valid;
    logic          m1_req;
    logic          m1_we;
    logic [AB-1:0] m1_addr;
    logic [DB-1:0] m1_wdata;
    logic [DB-1:0] m1_rdata;
    logic          m1_ack;
    logic [AB-1:0] s_addr;
    logic          s_wr_en;
    logic          s_rd_en;
    logic [DB-1:0] s_data_out;
    logic [DB-1:0] s_data_in;
    logic          busy;
    logic          err_overflow;

    fmc_bus_arbiter #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .RD_LATENCY(LAT), .STARVE_MAX(SMAX)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .m0_addr(m0_addr), .m0_wr_en(m0_wr_en), .m0_rd_en(m0_rd_en),
        .m0_data_out(m0_data_out), .m0_data_in(m0_data_in), .m0_rd_valid(m0_rd_valid),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack),
        .s_addr(s_addr), .s_wr_en(s_wr_en), .s_rd_en(s_rd_en),
        .s_data_out(s_data_out), .s_data_in(s_data_in),
        .busy(busy), .err_overflow(err_overflow)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    typedef struct { int cyc; logic we; logic [AB-1:0] addr; logic [DB-1:0] data; } op_t;
    typedef struct { int cyc; logic [DB-1:0] data; } rsp_t;

    op_t  slave_q[$];
    rsp_t m0_q[$];
    rsp_t m1_q[$];
    rsp_t rd_q[$];

    int            n_checks = 0;
    int            n_fail   = 0;
    int            cur_cyc  = 0;
    int            next_idle = 0;
    int            starve   = 0;
    int            m1_state = 0;
    int            m1_release = 0;
    logic          pv = 1'b0;
    logic          pwe = 1'b0;
    logic [AB-1:0] pa = '0;
    logic [DB-1:0] pd = '0;
    logic          ovf = 1'b0;
    logic [DB-1:0] m1_last = '0;
    logic          exp_busy = 1'b0;
    logic          exp_ovf = 1'b0;
    logic          force_v = 1'b0;
    logic [DB-1:0] force_d = '0;
    logic          mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cur_cyc, act, exp);
        end
    endtask

    function automatic logic [DB-1:0] pick_rd();
        if (force_v) begin
            force_v = 1'b0;
            return force_d;
        end
        return DB'($urandom());
    endfunction

    function automatic bit idle_next();
        return (cur_cyc + 1 >= next_idle);
    endfunction

    // A granted transaction fixes every later observable event and its cycle.
    task automatic issue(input logic we, input logic [AB-1:0] a, input logic [DB-1:0] d, input bit is_m1);
        op_t           o;
        rsp_t          r;
        logic [DB-1:0] rd;
        int            dur;
        dur = we ? 3 : LAT + 3;
        rd  = '0;
        o.cyc = cur_cyc + 1; o.we = we; o.addr = a; o.data = d;
        slave_q.push_back(o);
        if (!we) begin
            rd = pick_rd();
            r.cyc = cur_cyc + 1; r.data = rd;
            rd_q.push_back(r);
        end
        r.cyc = cur_cyc + dur - 1;
        if (is_m1) begin
            if (!we) m1_last = rd;
            r.data = m1_last;
            m1_q.push_back(r);
            m1_state   = 2;
            m1_release = cur_cyc + dur;
        end else if (!we) begin
            r.data = rd;
            m0_q.push_back(r);
        end
        next_idle = cur_cyc + dur;
    endtask

    task automatic step_full(input logic wr, input logic rd, input logic [AB-1:0] a, input logic [DB-1:0] d,
                             input logic m1go, input logic m1w, input logic [AB-1:0] m1a,
                             input logic [DB-1:0] m1d, input logic rst_in);
        logic strobe, m0c, g0, g1;
        @(posedge sys_clk);
        #1;
        cur_cyc++;
        exp_busy = (cur_cyc < next_idle);
        exp_ovf  = ovf;
        if (m1_state == 2 && cur_cyc == m1_release) begin
            m1_state = 0;
            m1_req   = 1'b0;
        end
        if (m1_state == 2) begin
            m1_we = 1'($urandom()); m1_addr = AB'($urandom()); m1_wdata = DB'($urandom());
        end else if (m1_state == 0 && m1go && !rst_in) begin
            m1_state = 1; m1_req = 1'b1; m1_we = m1w; m1_addr = m1a; m1_wdata = m1d;
        end
        sys_rst     = rst_in;
        m0_wr_en    = wr & ~rst_in;
        m0_rd_en    = rd & ~rst_in;
        m0_addr     = a;
        m0_data_out = d;
        if (rst_in) begin
            pv = 1'b0; starve = 0; ovf = 1'b0; m1_last = '0;
            next_idle = cur_cyc + 1;
            m1_state = 0; m1_req = 1'b0;
            while (slave_q.size() > 0 && slave_q[$].cyc > cur_cyc) void'(slave_q.pop_back());
            while (m0_q.size() > 0 && m0_q[$].cyc > cur_cyc) void'(m0_q.pop_back());
            while (m1_q.size() > 0 && m1_q[$].cyc > cur_cyc) void'(m1_q.pop_back());
            while (rd_q.size() > 0 && rd_q[$].cyc > cur_cyc) void'(rd_q.pop_back());
            return;
        end
        strobe = wr | rd;
        if (cur_cyc >= next_idle) begin
            m0c = pv | strobe;
            g1  = m1_req && (!m0c || starve == SMAX);
            g0  = m0c && !g1;
            if (g1) begin
                issue(m1_we, m1_addr, m1_wdata, 1'b1);
                starve = 0;
            end
            if (g0) begin
                if (m1_req && starve < SMAX) starve++;
                if (pv) begin
                    issue(pwe, pa, pd, 1'b0);
                    pv = 1'b0;
                end else begin
                    issue(wr, a, d, 1'b0);
                    strobe = 1'b0;
                end
            end
        end
        if (strobe) begin
            if (!pv) begin
                pv = 1'b1; pwe = wr; pa = a; pd = d;
            end else begin
                ovf = 1'b1;
            end
        end
    endtask

    task automatic step0();
        step_full(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic step_m0(input logic wr, input logic rd, input logic [AB-1:0] a, input logic [DB-1:0] d);
        step_full(wr, rd, a, d, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic step_rand(input bit gated);
        logic wr, rd, go, ok;
        int   k;
        wr = 1'b0; rd = 1'b0;
        go = ($urandom_range(0, 9) < 3);
        if ($urandom_range(0, 9) < 4) begin
            k  = $urandom_range(0, 2);
            wr = (k != 1);
            rd = (k != 0);
        end
        ok = !pv || (idle_next() && !go && (m1_state != 1 || starve < SMAX));
        if (gated && !ok) begin
            wr = 1'b0; rd = 1'b0;
        end
        step_full(wr, rd, AB'($urandom()), DB'($urandom()), go, 1'($urandom()),
                  AB'($urandom()), DB'($urandom()), 1'b0);
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (!(idle_next() && !pv && m1_state == 0) && i < 300) begin
            step0();
            i++;
        end
        if (i >= 300) begin
            n_checks++; n_fail++;
            $display("FAIL drain: model never returned to idle");
        end
    endtask

    task automatic check_all_zero(input string tag);
        @(negedge sys_clk);
        chk({tag, "_m0_data_in"}, 64'(m0_data_in), 64'd0);
        chk({tag, "_m0_rd_valid"}, 64'(m0_rd_valid), 64'd0);
        chk({tag, "_m1_rdata"}, 64'(m1_rdata), 64'd0);
        chk({tag, "_m1_ack"}, 64'(m1_ack), 64'd0);
        chk({tag, "_s_addr"}, 64'(s_addr), 64'd0);
        chk({tag, "_s_wr_en"}, 64'(s_wr_en), 64'd0);
        chk({tag, "_s_rd_en"}, 64'(s_rd_en), 64'd0);
        chk({tag, "_s_data_out"}, 64'(s_data_out), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_err_overflow"}, 64'(err_overflow), 64'd0);
    endtask

    // Slave: read data is presented only for the one cycle the DUT must sample it.
    initial begin
        rsp_t          r;
        logic [DB-1:0] d;
        s_data_in = DB'($urandom());
        forever begin
            @(negedge sys_clk);
            if (s_rd_en) begin
                if (rd_q.size() > 0) begin
                    r = rd_q.pop_front();
                    d = r.data;
                end else begin
                    d = DB'($urandom());
                end
                repeat (LAT) @(negedge sys_clk);
                s_data_in = d;
                @(negedge sys_clk);
                s_data_in = ~d;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    initial begin
        op_t  o;
        rsp_t r;
        forever begin
            @(negedge sys_clk);
            if (mon_en) begin
                chk("busy", 64'(busy), 64'(exp_busy));
                chk("err_overflow", 64'(err_overflow), 64'(exp_ovf));
                if (s_wr_en || s_rd_en) begin
                    chk("s_strobe_exclusive", 64'(s_wr_en & s_rd_en), 64'd0);
                    if (slave_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL slave_op: unexpected strobe at cycle %0d, got wr=%0b rd=%0b, expected none",
                                 cur_cyc, s_wr_en, s_rd_en);
                    end else begin
                        o = slave_q.pop_front();
                        chk("slave_cycle", 64'(cur_cyc), 64'(o.cyc));
                        chk("slave_dir", 64'(s_wr_en), 64'(o.we));
                        chk("slave_addr", 64'(s_addr), 64'(o.addr));
                        if (o.we) chk("slave_wdata", 64'(s_data_out), 64'(o.data));
                    end
                end
                if (m0_rd_valid) begin
                    if (m0_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL m0_rd_valid: unexpected pulse at cycle %0d, got 1, expected 0", cur_cyc);
                    end else begin
                        r = m0_q.pop_front();
                        chk("m0_cycle", 64'(cur_cyc), 64'(r.cyc));
                        chk("m0_data_in", 64'(m0_data_in), 64'(r.data));
                    end
                end
                if (m1_ack) begin
                    if (m1_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL m1_ack: unexpected pulse at cycle %0d, got 1, expected 0", cur_cyc);
                    end else begin
                        r = m1_q.pop_front();
                        chk("m1_cycle", 64'(cur_cyc), 64'(r.cyc));
                        chk("m1_rdata", 64'(m1_rdata), 64'(r.data));
                    end
                end
            end
        end
    end

    initial begin
        sys_rst = 1'b1;
        m0_addr = '0; m0_wr_en = 1'b0; m0_rd_en = 1'b0; m0_data_out = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;

        step_full(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
        step_full(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
        mon_en = 1'b1;
        check_all_zero("reset");
        step0();

        // m0 write then m0 read with a fixed slave return
        step_m0(1'b1, 1'b0, 24'h000000, 32'hDEADBEEF);
        drain();
        force_v = 1'b1; force_d = 32'h12345678;
        step_m0(1'b0, 1'b1, 24'h000004, 32'h0);
        drain();

        // m1 alone: write then read
        step_full(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 24'h000010, 32'hA5A5A5A5, 1'b0);
        drain();
        force_v = 1'b1; force_d = 32'h0BADF00D;
        step_full(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 24'h000010, 32'h0, 1'b0);
        drain();

        // m0 read strobe lands in m1's WAIT window
        step_full(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 24'h000020, 32'h0, 1'b0);
        step0();
        step_m0(1'b0, 1'b1, 24'h000044, 32'h0);
        drain();

        // starvation: m1 held while m0 strobes at every free IDLE
        step_full(1'b1, 1'b0, 24'h000100, 32'h11110000, 1'b1, 1'b1, 24'h000030, 32'hCAFEF00D, 1'b0);
        for (int i = 0; i < 60; i++) begin
            if (idle_next()) step_m0(1'($urandom()), 1'b1, AB'(24'h000200 + i), DB'($urandom()));
            else step0();
        end
        drain();

        for (int i = 0; i < 1500; i++) step_rand(1'b1);
        drain();

        // overflow: two strobes inside one read window
        step_m0(1'b0, 1'b1, 24'h000300, 32'h0);
        step_m0(1'b1, 1'b0, 24'h000304, 32'h55AA55AA);
        step_m0(1'b0, 1'b1, 24'h000308, 32'h0);
        drain();
        for (int i = 0; i < 400; i++) step_rand(1'b0);
        drain();

        // reset during WAIT discards the in-flight read
        step_m0(1'b0, 1'b1, 24'h000400, 32'h0);
        step0();
        step_full(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
        step0();
        check_all_zero("midreset");
        for (int i = 0; i < 20; i++) step0();
        for (int i = 0; i < 200; i++) step_rand(1'b1);
        drain();
        repeat (3) step0();
        @(negedge sys_clk);
        #1;
        chk("slave_q_empty", 64'(slave_q.size()), 64'd0);
        chk("m0_q_empty", 64'(m0_q.size()), 64'd0);
        chk("m1_q_empty", 64'(m1_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
